// File: rtl/xor_accum_pkg.sv
// Shared constants for the XOR accumulate unit.
//   mode_e      : beat mode encoding (MODE_BEAT / MODE_ACCUM)
//   DEF_WIDTH   : default channel / result width
//   DEF_NCH     : default number of channels XORed per beat
//   DEF_CNT_W   : default beat counter width
package xor_accum_pkg;

    typedef enum logic {
        MODE_BEAT  = 1'b0,
        MODE_ACCUM = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 2;
    localparam int DEF_CNT_W = 2;

endpackage

// File: rtl/xor_reduce_nch.sv
// Combinational XOR of NCH packed channels into one WIDTH-bit word.
//   data_i   : NCH*WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   beat_x_o : bitwise XOR of all channels
module xor_reduce_nch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
) (
    input  logic [NCH*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]     beat_x_o
);

    always_comb begin
        beat_x_o = '0;
        for (int k = 0; k < NCH; k++) begin
            beat_x_o = beat_x_o ^ data_i[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/xor_accum_unit.sv
// XOR accumulate unit: XORs NCH channels per beat and either emits the
// result per beat (MODE_BEAT) or folds a whole frame into one result
// (MODE_ACCUM, closed by in_last). One-entry output register with
// valid/ready handshake on both sides.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : input beat handshake
//   in_data, in_last, mode        : beat payload, frame end, mode select
//   out_valid/out_ready           : result handshake
//   out_data, out_parity          : result and its reduction XOR
//   beat_cnt                      : accepted beats modulo 2^CNT_W
module xor_accum_unit
    import xor_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic                 in_last,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_parity,
    output logic [CNT_W-1:0]     beat_cnt
);

    logic [WIDTH-1:0] beat_x;
    logic             accept;
    mode_e            eff_mode;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    // Latched frame mode: MODE_ACCUM only while an accumulate frame is open,
    // so it doubles as the "frame in progress" flag.
    mode_e            mode_q,      mode_d;

    xor_reduce_nch #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_reduce (
        .data_i   (in_data),
        .beat_x_o (beat_x)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Mid-frame mode changes are ignored: an open frame keeps its mode.
    assign eff_mode = (mode_q == MODE_ACCUM) ? MODE_ACCUM : mode_e'(mode);

    always_comb begin
        out_data_d  = out_data_q;
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (eff_mode == MODE_BEAT) begin
                out_data_d  = beat_x;
                out_valid_d = 1'b1;
            end else if (in_last) begin
                out_data_d  = acc_q ^ beat_x;
                out_valid_d = 1'b1;
                acc_d       = '0;
                mode_d      = MODE_BEAT;
            end else begin
                acc_d  = acc_q ^ beat_x;
                mode_d = MODE_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            mode_q      <= MODE_BEAT;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = ^out_data_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_xor_accum_unit.sv
module tb_xor_accum_unit;

    localparam int W = 8;
    localparam int N = 2;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           in_last = 1'b0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_parity;
    logic [C-1:0]   beat_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] sb[$];

    xor_accum_unit #(.WIDTH(W), .NCH(N), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model + scoreboard, sampled on the falling edge while inputs
    // are stable; results are queued when the producing beat is accepted.
    initial begin
        logic         m_valid = 1'b0;
        logic [C-1:0] m_cnt = '0;
        logic [W-1:0] m_acc = '0;
        logic         m_frame = 1'b0;
        logic [W-1:0] bx;
        logic         prod;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_valid = 1'b0; m_cnt = '0; m_acc = '0; m_frame = 1'b0;
                sb.delete();
                chk("rst_vld", 32'(out_valid), 32'd0);
                chk("rst_cnt", 32'(beat_cnt), 32'd0);
                chk("rst_rdy", 32'(in_ready), 32'd1);
            end else begin
                chk("rdy", 32'(in_ready), 32'(!m_valid || out_ready));
                chk("vld", 32'(out_valid), 32'(m_valid));
                chk("cnt", 32'(beat_cnt), 32'(m_cnt));
                if (m_valid) begin
                    if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
                    else begin
                        chk("data", 32'(out_data), 32'(sb[0]));
                        chk("par", 32'(out_parity), 32'(^sb[0]));
                    end
                end
                prod = 1'b0;
                if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
                if (in_valid && (!m_valid || out_ready)) begin
                    bx = '0;
                    for (int k = 0; k < N; k++) bx = bx ^ in_data[k*W +: W];
                    m_cnt = m_cnt + 2'd1;
                    if (m_frame || mode) begin
                        if (in_last) begin
                            sb.push_back(m_acc ^ bx);
                            m_acc = '0; m_frame = 1'b0; prod = 1'b1;
                        end else begin
                            m_acc = m_acc ^ bx; m_frame = 1'b1;
                        end
                    end else begin
                        sb.push_back(bx); prod = 1'b1;
                    end
                end
                m_valid = prod ? 1'b1 : (out_ready ? 1'b0 : m_valid);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic last, input logic m);
        logic ok = 1'b0;
        in_valid = 1'b1; in_data = {b, a}; in_last = last; mode = m;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C-1:0] cnt0;
        logic [C-1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        out_ready = 1'b1;
        do_reset();

        // per-beat XOR
        send(8'hA5, 8'h0F, 1'b0, 1'b0);
        chk("m0_data", 32'(out_data), 32'hAA);
        chk("m0_par", 32'(out_parity), 32'd0);
        chk("m0_vld", 32'(out_valid), 32'd1);

        // three-beat accumulate frame, then single-beat frame shows acc cleared
        send(8'h01, 8'h02, 1'b0, 1'b1);
        chk("acc_novld", 32'(out_valid), 32'd0);
        send(8'h04, 8'h00, 1'b0, 1'b1);
        chk("acc_novld2", 32'(out_valid), 32'd0);
        send(8'h10, 8'h20, 1'b1, 1'b1);
        chk("acc_data", 32'(out_data), 32'h37);
        chk("acc_par", 32'(out_parity), 32'd1);
        send(8'hAA, 8'h00, 1'b1, 1'b1);
        chk("acc_clr", 32'(out_data), 32'hAA);

        // backpressure: result held, no acceptance, then no-bubble replace
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h33, 8'h11, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = {8'hF0, 8'h0F}; mode = 1'b0;
        cnt0 = beat_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            chk("bp_data", 32'(out_data), 32'h22);
            chk("bp_cnt", 32'(beat_cnt), 32'(cnt0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_hi", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_new", 32'(out_data), 32'hFF);
        @(posedge clk); #1;
        chk("bp_clr", 32'(out_valid), 32'd0);

        // mode toggled mid-frame: still one accumulated result
        send(8'h01, 8'h00, 1'b0, 1'b1);
        send(8'h02, 8'h00, 1'b0, 1'b0);
        chk("tog_novld", 32'(out_valid), 32'd0);
        send(8'h04, 8'h00, 1'b1, 1'b0);
        chk("tog_data", 32'(out_data), 32'h07);

        // async reset mid-frame discards the partial accumulation
        send(8'h01, 8'h02, 1'b0, 1'b1);
        send(8'h40, 8'h00, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_par", 32'(out_parity), 32'd0);
        chk("arst_cnt", 32'(beat_cnt), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        send(8'hFF, 8'h0F, 1'b1, 1'b1);
        chk("arst_frame", 32'(out_data), 32'hF0);

        // counter wrap from a clean reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'(i), 8'h5A, 1'b0, 1'b0);
            chk("cnt_seq", 32'(beat_cnt), 32'(seq[i]));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/xor_accum_unit.md
XOR_ACCUM_UNIT -- requirements
Module: xor_accum_unit

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each input channel and of the result.
REQ-002 Parameter NCH, default 2: number of input channels XORed together; legal range 2..8.
REQ-003 Parameter CNT_W, default 2: width of the beat counter; the counter wraps at 2^CNT_W.
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: in_data, in_last and mode are valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 Port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port in_last, input, 1 bit: last beat of a frame; used in accumulate mode only.
REQ-011 Port mode, input, 1 bit: 0 = per-beat XOR; 1 = frame accumulate.
REQ-012 Port out_valid, output, 1 bit: out_data and out_parity are valid.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-014 Port out_data, output, WIDTH bits: XOR result.
REQ-015 Port out_parity, output, 1 bit: reduction XOR of out_data.
REQ-016 Port beat_cnt, output, CNT_W bits: number of accepted beats, modulo 2^CNT_W.

Function
REQ-017 A beat is accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-018 beat_x, the beat XOR, SHALL be the bitwise XOR of all NCH channels of the accepted beat.
REQ-019 Mode 0: an accepted beat SHALL load out_data = beat_x and set out_valid on the next cycle (latency 1).
REQ-020 Mode 1: accepted beats SHALL fold into acc (acc ^= beat_x); on the beat with in_last=1, out_data = acc ^ beat_x, out_valid SHALL set, and acc SHALL clear to 0.
REQ-021 Mode SHALL be latched on the first beat of a frame; mode changes mid-frame SHALL be ignored until the in_last beat is accepted.
REQ-022 A mode 1 frame of one beat with in_last=1 SHALL output beat_x.
REQ-023 out_valid SHALL stay high and out_data SHALL stay stable until out_ready=1.
REQ-024 Simultaneous out_ready=1 and a new producing beat SHALL replace the result with no bubble; out_valid stays high.
REQ-025 out_valid SHALL clear the cycle after a handshake if no new result is produced.
REQ-026 beat_cnt SHALL increment on every accepted beat in either mode and wrap from 2^CNT_W-1 to 0.
REQ-027 Non-last beats in mode 1 SHALL NOT assert out_valid.

Reset
REQ-028 While rst=1: out_valid=0, out_data=0, out_parity=0, beat_cnt=0, acc=0, and the latched mode=0, taking effect asynchronously.
REQ-029 in_ready SHALL be 1 while rst=1 but no beat SHALL be accepted; a frame in progress at reset SHALL be discarded.
REQ-030 Reset release SHALL take effect on the first clk edge after rst falls.

Structure
REQ-031 Package xor_accum_pkg SHALL hold the mode encoding constants MODE_BEAT=0 and MODE_ACCUM=1, and the default WIDTH, NCH and CNT_W values.
REQ-032 Sub-module xor_reduce_nch (parameters WIDTH and NCH, combinational) SHALL compute beat_x; all state SHALL live in xor_accum_unit.

Verification
REQ-033 Mode 0, WIDTH=8, NCH=2, inputs 0xA5 and 0x0F, out_ready=1 -> next cycle out_data=0xAA, out_parity=0, out_valid=1.
REQ-034 Mode 1, frame of beats (0x01,0x02), (0x04,0x00), last (0x10,0x20) -> exactly one out_valid, out_data=0x37, out_parity=1; acc=0 afterwards.
REQ-035 out_ready=0 for 3 cycles with a result pending -> in_ready=0, out_data held, beat_cnt unchanged; out_ready=1 -> the handshake completes and in_ready=1.
REQ-036 Five accepted beats with CNT_W=2 -> beat_cnt sequence 1,2,3,0,1.
REQ-037 Assert rst mid-frame in mode 1 after two beats -> outputs 0 immediately; the next one-beat last frame (0xFF,0x0F) -> out_data=0xF0.
REQ-038 Toggle mode from 1 to 0 mid-frame -> the frame still accumulates and produces a single result on in_last.
